report_frame_sequencer: RTL and testbench
=========================================

// Module: report_frame_sequencer
// PURPOSE
//  Downstream of the report BRAMs (count_b1/b2/b3, word_report). On a dump request it walks
//  record addresses 0..max_address-1, reads one record per frame, and streams each as 8 bytes
//  {OPEN,b1,MID,b2,b3,CLOSE,word,addr[7:0]} to the UART byte transmitter via start/busy.
//  Replaces the sel_mux/address-increment pair feeding the UART. Single clock domain.
// PARAMETERS
//  ADDR_W     16      record address width
//  BYTE_OPEN  8'h5B   frame byte 0
//  BYTE_MID   8'h5C   frame byte 2
//  BYTE_CLOSE 8'h5D   frame byte 5
//  BYTE_EOL   8'h0A   terminator sent once after last frame
//  SEND_EOL   1       1: send BYTE_EOL at end of dump; 0: omit
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  go           in   1       1-cycle pulse: start dump
//  max_address  in   ADDR_W  record count (report write pointer); sampled on accepted go
//  rd_en        out  1       BRAM read enable
//  rd_addr      out  ADDR_W  BRAM record address
//  rd_b1        in   8       count_b1 read data, valid 1 cycle after rd_en
//  rd_b2        in   8       count_b2 read data
//  rd_b3        in   8       count_b3 read data
//  rd_word      in   8       word_report read data
//  tx_data      out  8       byte to UART; stable while tx_start or tx_busy high
//  tx_start     out  1       level request; held until tx_busy seen high
//  tx_busy      in   1       UART busy
//  active       out  1       high from accepted go until done
//  done         out  1       1-cycle pulse at end of dump
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, record index 0, byte index 0.
//  go accepted only in IDLE; ignored when active=1. On accept: latch max_address, active=1.
//  max_address==0: go -> (SEND_EOL? send EOL : nothing) -> done; no rd_en asserted.
//  States: IDLE -> RD_REQ (rd_en=1, rd_addr=idx, 1 cycle) -> RD_WAIT (1 cycle) ->
//   LATCH (capture rd_b1/b2/b3/rd_word + idx[7:0] into 5-byte frame reg) -> SEND ->
//   ACK -> DRAIN -> (byte<7: SEND next byte; byte==7: NEXT) ;
//   NEXT: idx+1 < max -> RD_REQ; else EOL (if SEND_EOL) or FIN. FIN: done=1, active=0 -> IDLE.
//  SEND: drive tx_data=frame byte[bidx], tx_start=1 -> ACK. ACK: hold tx_start until tx_busy=1,
//   then drop tx_start -> DRAIN. DRAIN: wait tx_busy=0, then advance bidx.
//  tx_busy already high in SEND: wait in SEND (tx_start=0) until low before requesting.
//  Byte order fixed: OPEN, b1, MID, b2, b3, CLOSE, word, addr low byte.
//  Frame data latched once per record; BRAM changes during send do not affect the frame.
//  idx is ADDR_W bits, compare idx+1 at ADDR_W+1 bits: max=2^ADDR_W-1 terminates, no wrap.
//  addr byte is idx[7:0]; wraps mod 256 by design.
//  rd_en low except in RD_REQ; rd_addr holds last value otherwise.
//  rst mid-dump: next edge returns to IDLE, tx_start=0, active=0, no done pulse; the UART's
//   in-flight byte is the UART's concern. go in same cycle as rst: ignored.
//  go in same cycle as done: ignored (not IDLE yet).
// TESTING
//  T1 max=1, rec0={b1=01,b2=02,b3=03,w=AA}, UART model busy 10 cyc -> bytes 5B 01 5C 02 03 5D AA 00 0A, one done
//  T2 max=3 distinct records -> 3 frames, addr bytes 00 01 02, rd_addr 0,1,2, exactly 3 rd_en pulses, one 0A
//  T3 max=0 -> only 0A sent (SEND_EOL=1); with SEND_EOL=0 done 1-2 cycles after go, zero tx_start
//  T4 go pulsed during dump, and max_address changed mid-dump -> no restart, original count kept
//  T5 tx_busy held high at go for 50 cyc -> no tx_start until busy low; tx_data constant across busy window
//  T6 rst asserted at byte 4 of frame 1 -> next cycle tx_start=0, active=0, no done; new go restarts at idx 0

Source files
------------

// File: rtl/report_frame_sequencer.sv
// Walks report records 0..max_address-1 after a go pulse, reads one record per frame from
// the report BRAMs and streams it to the UART byte transmitter as 8 framed bytes.
module report_frame_sequencer #(
    parameter int          ADDR_W     = 16,
    parameter logic [7:0]  BYTE_OPEN  = 8'h5B,
    parameter logic [7:0]  BYTE_MID   = 8'h5C,
    parameter logic [7:0]  BYTE_CLOSE = 8'h5D,
    parameter logic [7:0]  BYTE_EOL   = 8'h0A,
    parameter bit          SEND_EOL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] max_address,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_b1,
    input  logic [7:0]        rd_b2,
    input  logic [7:0]        rd_b3,
    input  logic [7:0]        rd_word,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              active,
    output logic              done
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] RD_REQ  = 4'd1;
    localparam logic [3:0] RD_WAIT = 4'd2;
    localparam logic [3:0] LATCH   = 4'd3;
    localparam logic [3:0] SEND    = 4'd4;
    localparam logic [3:0] ACK     = 4'd5;
    localparam logic [3:0] DRAIN   = 4'd6;
    localparam logic [3:0] NEXT    = 4'd7;
    localparam logic [3:0] FIN     = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        bidx_q, bidx_d;
    logic [4:0][7:0]   frame_q, frame_d;   // {b1, b2, b3, word, addr}
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              eol_q, eol_d;       // current byte is the end-of-dump terminator
    logic [7:0]        frame_byte;
    logic [ADDR_W:0]   idx_nxt;

    // One extra bit so max_address = 2^ADDR_W-1 terminates instead of wrapping idx.
    assign idx_nxt = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        frame_byte = BYTE_OPEN;
        case (bidx_q)
            3'd0: frame_byte = BYTE_OPEN;
            3'd1: frame_byte = frame_q[4];
            3'd2: frame_byte = BYTE_MID;
            3'd3: frame_byte = frame_q[3];
            3'd4: frame_byte = frame_q[2];
            3'd5: frame_byte = BYTE_CLOSE;
            3'd6: frame_byte = frame_q[1];
            default: frame_byte = frame_q[0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        max_d      = max_q;
        rd_addr_d  = rd_addr_q;
        bidx_d     = bidx_q;
        frame_d    = frame_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        eol_d      = eol_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    max_d  = max_address;
                    idx_d  = '0;
                    bidx_d = '0;
                    eol_d  = 1'b0;
                    if (max_address != '0) begin
                        rd_addr_d = '0;
                        state_d   = RD_REQ;
                    end else if (SEND_EOL) begin
                        eol_d   = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = LATCH;
            LATCH: begin
                frame_d = {rd_b1, rd_b2, rd_b3, rd_word, idx_q[7:0]};
                bidx_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                // A UART still busy from someone else's byte is waited out before requesting.
                if (!tx_busy) begin
                    tx_data_d  = eol_q ? BYTE_EOL : frame_byte;
                    tx_start_d = 1'b1;
                    state_d    = ACK;
                end
            end
            ACK: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (eol_q) begin
                        state_d = FIN;
                    end else if (bidx_q == 3'd7) begin
                        state_d = NEXT;
                    end else begin
                        bidx_d  = bidx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            NEXT: begin
                if (idx_nxt < {1'b0, max_q}) begin
                    idx_d     = idx_nxt[ADDR_W-1:0];
                    rd_addr_d = idx_nxt[ADDR_W-1:0];
                    state_d   = RD_REQ;
                end else if (SEND_EOL) begin
                    eol_d   = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            max_q      <= '0;
            rd_addr_q  <= '0;
            bidx_q     <= '0;
            frame_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            rd_addr_q  <= rd_addr_d;
            bidx_q     <= bidx_d;
            frame_q    <= frame_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            eol_q      <= eol_d;
        end
    end

    assign rd_en    = (state_q == RD_REQ);
    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign done     = (state_q == FIN);
    assign active   = (state_q != IDLE) && (state_q != FIN);

endmodule

// File: tb/tb_report_frame_sequencer.sv
// Directed bench for report_frame_sequencer: BRAM and UART behavioural models, byte log,
// one task per scenario with hand-built expected frames.
module tb_report_frame_sequencer;

    logic        clk;
    logic        rst, go, go0;
    logic [15:0] max_address;
    logic        rd_en, rd_en0;
    logic [15:0] rd_addr, rd_addr0;
    logic [7:0]  rd_b1, rd_b2, rd_b3, rd_word;
    logic [7:0]  tx_data, tx_data0;
    logic        tx_start, tx_start0;
    logic        tx_busy, tx_busy0;
    logic        active, active0, done, done0;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_b1 [0:7];
    logic [7:0] m_b2 [0:7];
    logic [7:0] m_b3 [0:7];
    logic [7:0] m_w  [0:7];

    logic [7:0]  byte_q [$];
    logic [7:0]  exp_q  [$];
    logic [15:0] addr_q [$];
    int rd_cnt = 0, done_cnt = 0, done0_cnt = 0, start0_cnt = 0, rd0_cnt = 0;
    int data_chg = 0, hold_chg = 0, hold_starts = 0;
    bit busy_hold = 0;
    logic [7:0] hold_data = '0;

    report_frame_sequencer #(.SEND_EOL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .go(go), .max_address(max_address),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_b1(rd_b1), .rd_b2(rd_b2), .rd_b3(rd_b3),
        .rd_word(rd_word), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .active(active), .done(done)
    );

    report_frame_sequencer #(.SEND_EOL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .go(go0), .max_address(max_address),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_b1(rd_b1), .rd_b2(rd_b2), .rd_b3(rd_b3),
        .rd_word(rd_word), .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0),
        .active(active0), .done(done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM: data valid the cycle after rd_en, held one more cycle, then scrambled so a
    // frame captured at the wrong time shows up as 8'hEE.
    initial begin
        int since;
        logic [2:0] ra;
        since = 99;
        ra = '0;
        rd_b1 = 8'hEE; rd_b2 = 8'hEE; rd_b3 = 8'hEE; rd_word = 8'hEE;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                since = 0;
                ra = rd_addr[2:0];
                rd_b1 = 8'hEE; rd_b2 = 8'hEE; rd_b3 = 8'hEE; rd_word = 8'hEE;
            end else begin
                if (since < 99) since++;
                if (since == 1) begin
                    rd_b1 = m_b1[ra]; rd_b2 = m_b2[ra]; rd_b3 = m_b3[ra]; rd_word = m_w[ra];
                end else if (since == 3) begin
                    rd_b1 = 8'hEE; rd_b2 = 8'hEE; rd_b3 = 8'hEE; rd_word = 8'hEE;
                end
            end
        end
    end

    // UART: accepts a byte when start is seen while idle, then busy for 10 cycles.
    initial begin
        int busy_cnt;
        logic [7:0] held;
        busy_cnt = 0;
        held = '0;
        tx_busy = 1'b0;
        tx_busy0 = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_hold) begin
                tx_busy = 1'b1;
                busy_cnt = 0;
                if (tx_start) hold_starts++;
                if (tx_data !== hold_data) hold_chg++;
            end else if (busy_cnt > 0) begin
                if (tx_data !== held) data_chg++;
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else begin
                tx_busy = 1'b0;
                if (tx_start) begin
                    held = tx_data;
                    byte_q.push_back(tx_data);
                    tx_busy = 1'b1;
                    busy_cnt = 10;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) begin rd_cnt++; addr_q.push_back(rd_addr); end
            if (done) done_cnt++;
            if (done0) done0_cnt++;
            if (tx_start0) start0_cnt++;
            if (rd_en0) rd0_cnt++;
        end
    end

    task automatic clear_logs();
        byte_q.delete(); exp_q.delete(); addr_q.delete();
        rd_cnt = 0; done_cnt = 0;
    endtask

    task automatic add_frame(input int r);
        exp_q.push_back(8'h5B); exp_q.push_back(m_b1[r]); exp_q.push_back(8'h5C);
        exp_q.push_back(m_b2[r]); exp_q.push_back(m_b3[r]); exp_q.push_back(8'h5D);
        exp_q.push_back(m_w[r]);  exp_q.push_back(8'(r));
    endtask

    task automatic pulse_go(input logic [15:0] m);
        @(negedge clk);
        max_address = m;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin ok = 1; break; end
        end
    endtask

    task automatic cmp_bytes(input string name);
        checks++;
        if (byte_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s byte count got %0d want %0d", name, byte_q.size(), exp_q.size());
        end
        for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte %0d got %02h want %02h", name, i, byte_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; go0 = 1'b0; max_address = 16'd1;
        repeat (3) @(negedge clk);
        go = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({tx_start, active, done, rd_en, tx_start0, active0, done0, rd_en0} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %08b want 00000000",
                     {tx_start, active, done, rd_en, tx_start0, active0, done0, rd_en0});
        end
        checks++;
        if ({rd_addr, tx_data, rd_addr0, tx_data0} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got %012h want 0", {rd_addr, tx_data, rd_addr0, tx_data0});
        end
        rst = 1'b0; go = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL go_during_rst active got %b want 0", active);
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        add_frame(0); exp_q.push_back(8'h0A);
        pulse_go(16'd1);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_timeout done got 0 want 1"); end
        cmp_bytes("t1");
        repeat (5) @(negedge clk); #1;
        checks++;
        if (done_cnt != 1 || active !== 1'b0) begin
            errors++;
            $display("FAIL t1_done count got %0d active %b want 1 active 0", done_cnt, active);
        end
    endtask

    task automatic test_multi();
        bit ok;
        clear_logs();
        add_frame(0); add_frame(1); add_frame(2); exp_q.push_back(8'h0A);
        pulse_go(16'd3);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_timeout done got 0 want 1"); end
        cmp_bytes("t2");
        checks++;
        if (rd_cnt != 3) begin
            errors++;
            $display("FAIL t2_rd_en pulses got %0d want 3", rd_cnt);
        end
        for (int i = 0; i < addr_q.size() && i < 3; i++) begin
            checks++;
            if (addr_q[i] !== 16'(i)) begin
                errors++;
                $display("FAIL t2_rd_addr %0d got %0d want %0d", i, addr_q[i], i);
            end
        end
    endtask

    task automatic test_empty();
        bit ok;
        logic d1, d2;
        clear_logs();
        exp_q.push_back(8'h0A);
        pulse_go(16'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t3_timeout done got 0 want 1"); end
        cmp_bytes("t3");
        checks++;
        if (rd_cnt != 0) begin
            errors++;
            $display("FAIL t3_rd_en pulses got %0d want 0", rd_cnt);
        end
        @(negedge clk);
        go0 = 1'b1;
        @(negedge clk); #1;
        d1 = done0;
        go0 = 1'b0;
        @(negedge clk); #1;
        d2 = done0;
        repeat (3) @(negedge clk); #1;
        checks++;
        if ((d1 | d2) !== 1'b1 || done0_cnt != 1) begin
            errors++;
            $display("FAIL t3_noeol_done got d1=%b d2=%b count=%0d want a single pulse within 2",
                     d1, d2, done0_cnt);
        end
        checks++;
        if (start0_cnt != 0 || rd0_cnt != 0 || active0 !== 1'b0) begin
            errors++;
            $display("FAIL t3_noeol_quiet starts=%0d rd=%0d active=%b want 0 0 0",
                     start0_cnt, rd0_cnt, active0);
        end
    endtask

    task automatic test_go_ignored();
        bit ok;
        clear_logs();
        add_frame(0); add_frame(1); exp_q.push_back(8'h0A);
        pulse_go(16'd2);
        repeat (30) @(negedge clk);
        max_address = 16'd5;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t4_timeout done got 0 want 1"); end
        cmp_bytes("t4");
        repeat (40) @(negedge clk); #1;
        checks++;
        if (rd_cnt != 2 || done_cnt != 1 || active !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_restart rd=%0d done=%0d active=%b want 2 1 0",
                     rd_cnt, done_cnt, active);
        end
    endtask

    task automatic test_busy_at_go();
        bit ok;
        clear_logs();
        add_frame(0); exp_q.push_back(8'h0A);
        @(negedge clk);
        hold_data = tx_data;
        hold_chg = 0; hold_starts = 0;
        busy_hold = 1;
        pulse_go(16'd1);
        repeat (50) @(negedge clk);
        busy_hold = 0;
        checks++;
        if (hold_starts != 0) begin
            errors++;
            $display("FAIL t5_start_while_busy got %0d cycles want 0", hold_starts);
        end
        checks++;
        if (hold_chg != 0) begin
            errors++;
            $display("FAIL t5_data_during_hold changes got %0d want 0", hold_chg);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t5_timeout done got 0 want 1"); end
        cmp_bytes("t5");
        checks++;
        if (data_chg != 0) begin
            errors++;
            $display("FAIL tx_data_stable changes while busy got %0d want 0", data_chg);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        clear_logs();
        pulse_go(16'd3);
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (byte_q.size() >= 13) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL t6_reach_byte got %0d bytes want 13", byte_q.size()); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (tx_start !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL t6_rst_outputs tx_start=%b active=%b want 0 0", tx_start, active);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk); #1;
        checks++;
        if (done_cnt != 0 || active !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_done done=%0d active=%b want 0 0", done_cnt, active);
        end
        clear_logs();
        add_frame(0); exp_q.push_back(8'h0A);
        pulse_go(16'd1);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_timeout done got 0 want 1"); end
        checks++;
        if (addr_q.size() != 1 || addr_q[0] !== 16'd0) begin
            errors++;
            $display("FAIL t6_restart_idx reads=%0d want 1 at addr 0", addr_q.size());
        end
        cmp_bytes("t6");
    endtask

    initial begin
        m_b1[0] = 8'h01; m_b2[0] = 8'h02; m_b3[0] = 8'h03; m_w[0] = 8'hAA;
        m_b1[1] = 8'h11; m_b2[1] = 8'h12; m_b3[1] = 8'h13; m_w[1] = 8'hBB;
        m_b1[2] = 8'h21; m_b2[2] = 8'h22; m_b3[2] = 8'h23; m_w[2] = 8'hCC;
        for (int i = 3; i < 8; i++) begin
            m_b1[i] = 8'h30 + 8'(i); m_b2[i] = 8'h40 + 8'(i);
            m_b3[i] = 8'h50 + 8'(i); m_w[i]  = 8'h60 + 8'(i);
        end
        rst = 1'b1; go = 1'b0; go0 = 1'b0; max_address = '0;
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_go_ignored();
        test_busy_at_go();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
